// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter
// Brief    : Round-robin two-port arbiter sharing one sram_ctrl, with a
//            WAIT-state watchdog that recovers from a missing ready.
// Revision : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
    parameter int AW   = 18,
    parameter int DW   = 16,
    parameter int TO_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          rw0,
    input  logic          rw1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          gnt,
    output logic          busy,
    output logic          err,
    output logic          mem,
    output logic          rw,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data_f2s,
    input  logic          ready,
    input  logic [DW-1:0] data_s2f_r
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Leaving WAIT from this count means the counter has just reached all-ones.
    localparam logic [TO_W-1:0] C_WD_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    logic [1:0]      r_state;
    logic            r_last;
    logic [TO_W-1:0] r_wd;
    logic            r_gnt;
    logic            r_rw;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_data;
    logic [DW-1:0]   r_rdata0;
    logic [DW-1:0]   r_rdata1;
    logic            r_err;

    logic            w_any_req;
    logic            w_winner;
    logic            w_ready_ok;
    logic            w_timeout;

    assign w_any_req  = req0 | req1;
    // On a tie the port that was not served last wins.
    assign w_winner   = (req0 && req1) ? ~r_last : req1;
    // The first WAIT cycle still sees the controller's idle-level ready.
    assign w_ready_ok = ready && (r_wd != '0);
    assign w_timeout  = (r_wd == C_WD_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_last   <= 1'b1;
            r_wd     <= '0;
            r_gnt    <= 1'b0;
            r_rw     <= 1'b1;
            r_addr   <= '0;
            r_data   <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ready && w_any_req) begin
                        r_state <= S_ISSUE;
                        r_gnt   <= w_winner;
                        r_last  <= w_winner;
                        r_rw    <= w_winner ? rw1    : rw0;
                        r_addr  <= w_winner ? addr1  : addr0;
                        r_data  <= w_winner ? wdata1 : wdata0;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                    r_wd    <= '0;
                end
                S_WAIT: begin
                    r_wd <= r_wd + 1'b1;
                    if (w_ready_ok) begin
                        r_state <= S_DONE;
                        if (r_rw) begin
                            if (r_gnt) r_rdata1 <= data_s2f_r;
                            else       r_rdata0 <= data_s2f_r;
                        end
                    end else if (w_timeout) begin
                        r_state <= S_DONE;
                        r_err   <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem      = (r_state == S_ISSUE);
    assign busy     = (r_state != S_IDLE);
    assign ack0     = (r_state == S_DONE) && !r_gnt;
    assign ack1     = (r_state == S_DONE) &&  r_gnt;
    assign gnt      = r_gnt;
    assign rw       = r_rw;
    assign addr     = r_addr;
    assign data_f2s = r_data;
    assign rdata0   = r_rdata0;
    assign rdata1   = r_rdata1;
    assign err      = r_err;

endmodule
`default_nettype wire
